game_controller: RTL and testbench

GAME_CONTROLLER -- requirements
Module: game_controller

---
 rtl/game_controller.sv | 122 ++++++++++++
 tb/tb_game_controller.sv | 128 ++++++++++++
 2 files changed

// File: rtl/game_controller.sv
// game_controller -- control FSM for a memory/sequence game.
//
// Walks the game through setup, FPGA sequence display, user entry,
// per-entry check, round advance and result display. Drives the datapath
// through clear (R1/R2) and enable (E1..E4) strobes and reads back its
// status flags.
//
// Ports
//   CLOCK_50  in   sole clock, rising edge
//   R         in   synchronous active-high reset
//   ENTER     in   confirm button (already synchronised)
//   end_FPGA  in   FPGA finished showing the sequence
//   end_User  in   user entered the whole sequence for this round
//   end_time  in   user time limit expired
//   win       in   final round completed
//   match     in   last user entry equals the expected one
//   R1        out  clear round/sequence/user counters
//   R2        out  clear time counter
//   E1        out  latch setup switches
//   E2        out  enable time counter
//   E3        out  enable sequence-display counter
//   E4        out  one-cycle strobe latching a user entry (Mealy)
//   SEL       out  select result display on hex5
//   state     out  current state code (debug), p_state bits wide
//
// Build option: define ENTER_EDGE_DETECT_EN to turn ENTER into a
// rising-edge detected pulse; otherwise ENTER is used as a pulse directly.
module game_controller #(
  parameter int p_state = 3
) (
  input  logic               CLOCK_50,
  input  logic               R,
  input  logic               ENTER,
  input  logic               end_FPGA,
  input  logic               end_User,
  input  logic               end_time,
  input  logic               win,
  input  logic               match,
  output logic               R1,
  output logic               R2,
  output logic               E1,
  output logic               E2,
  output logic               E3,
  output logic               E4,
  output logic               SEL,
  output logic [p_state-1:0] state
);

  typedef enum logic [2:0] {
    INIT       = 3'd0,
    SETUP      = 3'd1,
    PLAY_FPGA  = 3'd2,
    PLAY_USER  = 3'd3,
    CHECK      = 3'd4,
    NEXT_ROUND = 3'd5,
    RESULT     = 3'd6
  } state_t;

  state_t r_state;
  logic   w_enter;

`ifdef ENTER_EDGE_DETECT_EN
  // History resets high so a button held across reset release is not
  // mistaken for a fresh press.
  logic r_enter_d;

  always_ff @(posedge CLOCK_50) begin
    if (R) r_enter_d <= 1'b1;
    else   r_enter_d <= ENTER;
  end

  assign w_enter = ENTER & ~r_enter_d;
`else
  assign w_enter = ENTER;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (R) begin
      r_state <= INIT;
    end else begin
      case (r_state)
        INIT:       r_state <= SETUP;
        SETUP:      if (w_enter) r_state <= PLAY_FPGA;
        PLAY_FPGA:  if (end_FPGA) r_state <= PLAY_USER;
        // Timeout beats a simultaneous enter.
        PLAY_USER:  if (end_time)     r_state <= RESULT;
                    else if (w_enter) r_state <= CHECK;
        CHECK:      if (!match)        r_state <= RESULT;
                    else if (win)      r_state <= RESULT;
                    else if (end_User) r_state <= NEXT_ROUND;
                    else               r_state <= PLAY_USER;
        NEXT_ROUND: r_state <= PLAY_FPGA;
        RESULT:     if (w_enter) r_state <= INIT;
        default:    r_state <= INIT;  // unused code 7
      endcase
    end
  end

  // Moore outputs: pure decode of the registered state.
  always_comb begin
    R1  = 1'b0;
    R2  = 1'b0;
    E1  = 1'b0;
    E2  = 1'b0;
    E3  = 1'b0;
    SEL = 1'b0;
    case (r_state)
      INIT:       begin R1 = 1'b1; R2 = 1'b1; end
      SETUP:      E1 = 1'b1;
      PLAY_FPGA:  begin E3 = 1'b1; R2 = 1'b1; end
      PLAY_USER:  E2 = 1'b1;
      NEXT_ROUND: R2 = 1'b1;
      RESULT:     SEL = 1'b1;
      default:    ;
    endcase
  end

  // Entry strobe is suppressed when the timeout wins the same cycle.
  assign E4    = (r_state == PLAY_USER) & w_enter & ~end_time;
  assign state = p_state'(r_state);

endmodule

// File: tb/tb_game_controller.sv
module tb_game_controller;

  logic       clk = 1'b0;
  logic       R, ENTER, end_FPGA, end_User, end_time, win, match;
  logic       R1, R2, E1, E2, E3, E4, SEL;
  logic [2:0] state;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model
  int m_state;
  bit m_prev;

  always #10 clk = ~clk;

  game_controller #(.p_state(3)) dut (
    .CLOCK_50(clk), .R(R), .ENTER(ENTER), .end_FPGA(end_FPGA),
    .end_User(end_User), .end_time(end_time), .win(win), .match(match),
    .R1(R1), .R2(R2), .E1(E1), .E2(E2), .E3(E3), .E4(E4), .SEL(SEL),
    .state(state)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit enter_of(bit btn, bit prev);
`ifdef ENTER_EDGE_DETECT_EN
    return btn && !prev;
`else
    return btn;
`endif
  endfunction

  // {R1,R2,E1,E2,E3,SEL} per state, straight from the state table.
  function automatic logic [7:0] moore_of(int s);
    case (s)
      0: return 8'b00_110000;
      1: return 8'b00_001000;
      2: return 8'b00_010010;
      3: return 8'b00_000100;
      5: return 8'b00_010000;
      6: return 8'b00_000001;
      default: return 8'b0;
    endcase
  endfunction

  function automatic int next_of(int s, bit en);
    if (R) return 0;
    case (s)
      0: return 1;
      1: return en ? 2 : 1;
      2: return end_FPGA ? 3 : 2;
      3: return end_time ? 6 : (en ? 4 : 3);
      4: return (!match || win) ? 6 : (end_User ? 5 : 3);
      5: return 2;
      6: return en ? 0 : 6;
      default: return 0;
    endcase
  endfunction

  task automatic check_now(string phase);
    bit en;
    en = enter_of(ENTER, m_prev);
    chk({phase, "_state"}, 8'(state), 8'(m_state));
    chk({phase, "_moore"}, {2'b0, R1, R2, E1, E2, E3, SEL}, moore_of(m_state));
    chk({phase, "_E4"}, 8'(E4), 8'(m_state == 3 && en && !end_time));
  endtask

  task automatic step_model();
    bit en;
    en      = enter_of(ENTER, m_prev);
    m_state = next_of(m_state, en);
    m_prev  = R ? 1'b1 : ENTER;
  endtask

  task automatic drive(bit r, bit en, bit ef, bit eu, bit et, bit w, bit m);
    R = r; ENTER = en; end_FPGA = ef; end_User = eu;
    end_time = et; win = w; match = m;
  endtask

  bit btn;

  initial begin
    drive(1, 1, 0, 0, 0, 0, 1);
    @(posedge clk);
    m_state = 0; m_prev = 1;

    // Two reset cycles with the button held, then release with it still held.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); drive(1, 1, 0, 0, 0, 0, 1);
      #1 check_now("rst");
      @(posedge clk); step_model();
    end
    btn = 1;

    // Random play; biased so deep states (CHECK, NEXT_ROUND) are reached.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 2) == 0) btn = ~btn;
      drive($urandom_range(0, 149) == 0, btn,
            $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 9) != 0);
      #1 check_now("rand");
      @(posedge clk); step_model();
    end

    // Directed: held button through timeout collision and a reset in RESULT.
    @(negedge clk); drive(1, 0, 0, 0, 0, 0, 1);
    #1 check_now("dir");
    @(posedge clk); step_model();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      drive(m_state == 6 && c > 30, (c % 12) < 10, c > 8, 0, c == 20, 0, 1);
      #1 check_now("dir");
      @(posedge clk); step_model();
    end

    @(negedge clk); #1 check_now("end");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
